// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared types and constants for the nibble-serial arithmetic sequencer.
//   state_t    : sequencer FSM states (IDLE, RUN, DONE)
//   AU_OP_*    : opcodes presented to the 4-bit arithmetic unit
// ---------------------------------------------------------------------------
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] AU_OP_IDLE = 2'b00;
  localparam logic [1:0] AU_OP_ADD  = 2'b01;
  localparam logic [1:0] AU_OP_SUB  = 2'b10;

endpackage

// File: rtl/arith_nibble_flags.sv
// ---------------------------------------------------------------------------
// arith_nibble_flags
// Combinational derivation of the carry/borrow chain bit and the signed
// overflow flag from the most-significant bits of one nibble step.
//   op        in  0 = add, 1 = subtract
//   a, b      in  MSBs of the operand nibbles driven to the unit
//   y         in  MSB of the result nibble returned by the unit
//   chain_out out carry out (add) or borrow out (sub) of this nibble
//   ovf_out   out signed overflow if this is the most-significant nibble
// ---------------------------------------------------------------------------
module arith_nibble_flags (
  input  logic op,
  input  logic a,
  input  logic b,
  input  logic y,
  output logic chain_out,
  output logic ovf_out
);

  // The unit's own carry flag is not used, so the chain bit is recovered
  // from the MSBs alone: for add, a carry leaves the nibble when both MSBs
  // are set, or when one is set and the sum MSB came out clear; subtract is
  // the borrow equivalent.
  always_comb begin
    chain_out = 1'b0;
    ovf_out   = 1'b0;
    if (!op) begin
      chain_out = (a & b) | ((a | b) & ~y);
      ovf_out   = (a == b) && (y != a);
    end else begin
      chain_out = (~a & b) | ((~a | b) & y);
      ovf_out   = (a != b) && (y != a);
    end
  end

endmodule

// File: rtl/arith_sequencer.sv
// ---------------------------------------------------------------------------
// arith_sequencer
// Drives an external combinational 4-bit arithmetic unit one nibble per
// cycle (least-significant first) to perform a WIDTH-bit add or subtract.
//
// Parameters
//   WIDTH        operand/result width, multiple of 4, >= 4
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   start        request, accepted only while busy = 0
//   op           0 = add, 1 = subtract
//   opa, opb     operands, sampled on an accepted start
//   busy         high while nibbles are being sequenced
//   done         one-cycle pulse; result/carry/ovf valid from this cycle
//   result       opa +/- opb mod 2^WIDTH
//   carry        carry out (add) or borrow out (sub)
//   ovf          signed two's-complement overflow
//   au_opCode    unit opcode (00 idle, 01 add, 10 sub)
//   au_A, au_B   operand nibbles for the current step
//   au_CarryIN   carry-in / borrow-in for the current step
//   au_add_Y     unit add result (reads 0 when not selected)
//   au_sub_Y     unit sub result (reads 0 when not selected)
//   chk_err      only with ARITH_SEQ_SELFCHECK_EN: high in the done cycle
//                when the collected result disagrees with a direct add/sub
//
// Optional feature macro: ARITH_SEQ_SELFCHECK_EN
// ---------------------------------------------------------------------------
module arith_sequencer
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic [1:0]       au_opCode,
  output logic [3:0]       au_A,
  output logic [3:0]       au_B,
  output logic             au_CarryIN,
  input  logic [3:0]       au_add_Y,
  input  logic [3:0]       au_sub_Y
`ifdef ARITH_SEQ_SELFCHECK_EN
  ,
  output logic             chk_err
`endif
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       au_op_q, au_op_d;
  logic [3:0]       au_a_q, au_a_d;
  logic [3:0]       au_b_q, au_b_d;
  // au_cin_q is also the running carry/borrow chain bit while in RUN.
  logic             au_cin_q, au_cin_d;

  logic [3:0]       y;
  logic             chain_next;
  logic             ovf_next;

`ifdef ARITH_SEQ_SELFCHECK_EN
  logic [WIDTH-1:0] golden;
  logic             chk_err_q, chk_err_d;
  assign golden = op_q ? (opa_q - opb_q) : (opa_q + opb_q);
`endif

  // Only one of the unit's results is non-zero, so OR picks the live one.
  assign y       = au_add_Y | au_sub_Y;
  assign idx_inc = idx_q + 1'b1;

  arith_nibble_flags u_flags (
    .op        (op_q),
    .a         (au_a_q[3]),
    .b         (au_b_q[3]),
    .y         (y[3]),
    .chain_out (chain_next),
    .ovf_out   (ovf_next)
  );

  // Next-state logic. The au_* drives are registered, so each RUN cycle
  // the unit sees the nibble for idx_q and its answer is captured on the
  // same clock edge that loads the drives for the following nibble.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    shadow_d = shadow_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    au_op_d  = au_op_q;
    au_a_d   = au_a_q;
    au_b_d   = au_b_q;
    au_cin_d = au_cin_q;
`ifdef ARITH_SEQ_SELFCHECK_EN
    chk_err_d = 1'b0;
`endif

    case (state_q)
      RUN: begin
        shadow_d[4*int'(idx_q) +: 4] = y;
        idx_d = idx_inc;
        if (idx_q == LAST_IDX) begin
          result_d = shadow_d;
          carry_d  = chain_next;
          ovf_d    = ovf_next;
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          au_op_d  = AU_OP_IDLE;
          au_a_d   = 4'h0;
          au_b_d   = 4'h0;
          au_cin_d = 1'b0;
`ifdef ARITH_SEQ_SELFCHECK_EN
          chk_err_d = (shadow_d != golden);
`endif
        end else begin
          au_a_d   = opa_q[4*int'(idx_inc) +: 4];
          au_b_d   = opb_q[4*int'(idx_inc) +: 4];
          au_cin_d = chain_next;
        end
      end

      default: begin
        // IDLE and DONE both accept a new request, which gives
        // back-to-back throughput of one operation per NIBBLES+1 cycles.
        if (start) begin
          opa_d    = opa;
          opb_d    = opb;
          op_d     = op;
          idx_d    = '0;
          state_d  = RUN;
          busy_d   = 1'b1;
          au_op_d  = op ? AU_OP_SUB : AU_OP_ADD;
          au_a_d   = opa[3:0];
          au_b_d   = opb[3:0];
          au_cin_d = 1'b0;
        end else begin
          state_d  = IDLE;
          au_op_d  = AU_OP_IDLE;
          au_a_d   = 4'h0;
          au_b_d   = 4'h0;
          au_cin_d = 1'b0;
        end
      end
    endcase
  end

  // Single state register for the whole sequencer; reset aborts any
  // operation in flight and returns every output to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= 1'b0;
      shadow_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      au_op_q  <= AU_OP_IDLE;
      au_a_q   <= 4'h0;
      au_b_q   <= 4'h0;
      au_cin_q <= 1'b0;
`ifdef ARITH_SEQ_SELFCHECK_EN
      chk_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      au_op_q  <= au_op_d;
      au_a_q   <= au_a_d;
      au_b_q   <= au_b_d;
      au_cin_q <= au_cin_d;
`ifdef ARITH_SEQ_SELFCHECK_EN
      chk_err_q <= chk_err_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign carry      = carry_q;
  assign ovf        = ovf_q;
  assign au_opCode  = au_op_q;
  assign au_A       = au_a_q;
  assign au_B       = au_b_q;
  assign au_CarryIN = au_cin_q;
`ifdef ARITH_SEQ_SELFCHECK_EN
  assign chk_err    = chk_err_q;
`endif

endmodule

// File: doc/arith_sequencer.md
# arith_sequencer

Multi-cycle initiator that drives the 4-bit arithmetic unit's operand/opcode interface to perform WIDTH-bit add or subtract, one nibble per cycle, least-significant nibble first. Sits between the datapath controller (start/done handshake) and the 4-bit arithmetic unit, whose result nibbles it collects. Carry and overflow are derived locally from operand and result MSBs, so the unit's combined CarryOUT/overflow flags are not consumed.

## Interface
- WIDTH, 8, operand/result width; multiple of 4, at least 4.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- op  in  1  0 = add, 1 = subtract.
- opa, opb  in  WIDTH  operands, sampled on accepted start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; result, carry and ovf are valid from this cycle.
- result  out  WIDTH  opa+opb or opa−opb, mod 2^WIDTH.
- carry  out  1  add: carry out; sub: borrow out (1 when opa < opb unsigned).
- ovf  out  1  signed two's-complement overflow.
- au_opCode  out  2  01 = add, 10 = sub, 00 = idle.
- au_A, au_B  out  4  current operand nibbles.
- au_CarryIN  out  1  add: carry-in; sub: borrow-in.
- au_add_Y, au_sub_Y  in  4  unit results; the unselected result reads 0.

## Operation
- Unit contract: add_Y = A+B+CarryIN; sub_Y = A−B−CarryIN (mod 16).
- FSM states IDLE, RUN, DONE; NIBBLES = WIDTH/4; index counter idx of width clog2(NIBBLES), min 1.
- IDLE/DONE, start=1:
  - latch opa, opb and op;
  - idx←0, chain bit←0;
  - go to RUN.
- RUN:
  - Drive au_A/au_B = nibble idx, au_opCode per op, au_CarryIN = chain bit.
  - Capture y = au_add_Y | au_sub_Y into shadow nibble idx.
  - Chain bit update, with a, b, y the nibble MSBs:
    - add: (a&b) | ((a|b)&~y);
    - sub: (~a&b) | ((~a|b)&y).
  - Increment idx.
  - On the last nibble:
    - ovf_next = add ? (a==b && y!=a) : (a!=b && y!=a);
    - result←shadow, carry←chain, ovf←ovf_next;
    - go to DONE.
- DONE: done=1 for one cycle, then IDLE unless start is accepted.
- IDLE/DONE, no start: au_opCode=00 and au_A/au_B/au_CarryIN=0.
- result/carry/ovf hold until the next operation completes. They do not change during RUN.
- start while busy=1 is ignored. Operand changes during RUN are ignored.

## Timing
- Reset (async): state IDLE. busy, done, result, carry, ovf, au_* all 0.
- start accepted in cycle t: busy=1 from t+1; RUN covers t+1..t+NIBBLES; done=1 at t+NIBBLES+1 (WIDTH=8: t+3).
- busy=0 in DONE, so start in the done cycle is accepted: back-to-back throughput is one operation per NIBBLES+1 cycles.
- Unit is combinational: capture happens in the same cycle the nibble is driven.
- Reset asserted mid-RUN aborts the operation: all outputs return to their reset values and no done pulse is produced.

## Configuration
- ARITH_SEQ_SELFCHECK_EN defined:
  - adds output port chk_err (1 bit, reset 0);
  - in the DONE cycle, chk_err=1 if result ≠ (opa ± opb) mod 2^WIDTH, computed directly from the latched operands;
  - chk_err is otherwise 0.
- Undefined: no chk_err port and no golden adder. Behaviour is otherwise identical.

## Structure
- Shared package arith_pkg holds:
  - state typedef {IDLE, RUN, DONE};
  - opcode constants AU_OP_IDLE=2'b00, AU_OP_ADD=2'b01, AU_OP_SUB=2'b10.
- One natural sub-module, arith_nibble_flags: combinational chain-bit and overflow derivation from a, b, y and op.
- The arithmetic unit is not instantiated; it connects through the au_* ports.

## Test plan (WIDTH=8, bench instantiates the arithmetic unit)
- add 0x3C+0x47 at t -> done at t+3, result 0x83, carry 0, ovf 1.
- add 0xFF+0x01 -> result 0x00, carry 1, ovf 0; au_CarryIN=1 on nibble 1.
- sub 0x10−0x01 -> 0x0F, carry 0, ovf 0; sub 0x00−0x01 -> 0xFF, carry 1, ovf 0; sub 0x80−0x01 -> 0x7F, ovf 1.
- start held high continuously: done every 3 cycles; start pulsed during RUN with new operands -> ignored, result unchanged.
- rst asserted during RUN nibble 1:
  - all outputs 0 immediately and au_opCode=00;
  - next start (0x12+0x34) -> result 0x46.
- With ARITH_SEQ_SELFCHECK_EN defined and au_add_Y bit 0 forced to 0 -> chk_err=1 in the done cycle.
